i2c_init_sequencer: RTL

- Walks a register-initialisation table and issues one I2C write transaction per entry, {DEV_ADDR+W, reg, val}, through the byte-level I2C master.
- Sits between power-up/reset control and the I2C master. Sequences sensor configuration without CPU involvement.
- Provides NACK retry, timed delay entries and per-run status.

---
 rtl/i2c_pkg.sv | 37 +++
 rtl/i2c_init_rom.sv | 19 +
 rtl/i2c_init_sequencer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-initialisation sequencer.
package i2c_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_SEND_ADDR,
        S_SEND_REG,
        S_SEND_VAL,
        S_DELAY,
        S_GAP,
        S_NEXT,
        S_DONE,
        S_FAIL
    } state_t;

    // Register field value that turns a table entry into a timed delay
    localparam logic [7:0] DELAY_REG = 8'hFF;
    // R/W bit appended to the 7-bit device address (write)
    localparam logic       I2C_WR    = 1'b0;

    // Table entry layout: {reg, val}
    localparam int REG_MSB = 15;
    localparam int REG_LSB = 8;
    localparam int VAL_MSB = 7;
    localparam int VAL_LSB = 0;

    // Default sensor bring-up table, entry 0 in the least significant word
    localparam logic [255:0] DEFAULT_TABLE = {
        16'hFF00, 16'hFF00, 16'h5480, 16'h535E,
        16'h5222, 16'h5100, 16'h5080, 16'h4F80,
        16'h1414, 16'h3A04, 16'h4010, 16'h3E00,
        16'h0C00, 16'h1101, 16'hFF04, 16'h1280
    };

endpackage

// File: rtl/i2c_init_rom.sv
// 16 x 16 initialisation table with one cycle of read latency.
module i2c_init_rom
    import i2c_pkg::*;
#(
    parameter logic [255:0] INIT = DEFAULT_TABLE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  addr,
    output logic [15:0] data
);

    // Registered table read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data <= '0;
        else        data <= INIT[{addr, 4'b0000} +: 16];
    end

endmodule

// File: rtl/i2c_init_sequencer.sv
// Walks a register table and issues one I2C write {DEV_ADDR+W, reg, val} per
// entry through a byte-level master, with NACK retry and timed delay entries.
module i2c_init_sequencer
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h21,
    parameter int         NUM_ENTRIES = 16,
    parameter int         TBL_AW      = 4,
    parameter int         MAX_RETRY   = 3,
    parameter int         GAP_CYCLES  = 64,
    parameter int         DELAY_UNIT  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [TBL_AW-1:0] tbl_addr,
    input  logic [15:0]       tbl_data,
    output logic              m_req,
    output logic              m_start,
    output logic              m_stop,
    output logic [7:0]        m_byte,
    input  logic              m_ack,
    input  logic              m_nack,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [TBL_AW-1:0] err_index
);

    localparam int DCNT_W = 8 + $clog2(DELAY_UNIT);
    localparam int RTY_W  = $clog2(MAX_RETRY + 2);
    localparam int GCNT_W = $clog2(GAP_CYCLES + 1);
    localparam logic [TBL_AW-1:0] LAST_IDX = TBL_AW'(NUM_ENTRIES - 1);

    state_t            state, state_d;
    logic [TBL_AW-1:0] index, index_d;
    logic [RTY_W-1:0]  retry, retry_d, retry_inc;
    logic [15:0]       ent, ent_d;
    logic [DCNT_W-1:0] dcnt, dcnt_d;
    logic [GCNT_W-1:0] gcnt, gcnt_d;
    logic              ok, ok_d;

    logic              m_req_d, m_start_d, m_stop_d;
    logic [7:0]        m_byte_d;
    logic              busy_d, done_d, error_d;
    logic [TBL_AW-1:0] err_index_d;

    // Responses only count while a byte is actually outstanding
    logic resp, resp_nack;
    assign resp      = m_req & (m_ack | m_nack);
    assign resp_nack = m_req & m_nack;
    assign retry_inc = retry + RTY_W'(1);

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            index     <= '0;
            retry     <= '0;
            ent       <= '0;
            dcnt      <= '0;
            gcnt      <= '0;
            ok        <= 1'b0;
            tbl_addr  <= '0;
            m_req     <= 1'b0;
            m_start   <= 1'b0;
            m_stop    <= 1'b0;
            m_byte    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_index <= '0;
        end else begin
            state     <= state_d;
            index     <= index_d;
            retry     <= retry_d;
            ent       <= ent_d;
            dcnt      <= dcnt_d;
            gcnt      <= gcnt_d;
            ok        <= ok_d;
            tbl_addr  <= index_d;
            m_req     <= m_req_d;
            m_start   <= m_start_d;
            m_stop    <= m_stop_d;
            m_byte    <= m_byte_d;
            busy      <= busy_d;
            done      <= done_d;
            error     <= error_d;
            err_index <= err_index_d;
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d = state;
        index_d = index;
        retry_d = retry;
        ent_d   = ent;
        dcnt_d  = dcnt;
        gcnt_d  = gcnt;
        ok_d    = ok;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    index_d = '0;
                    retry_d = '0;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                ent_d = tbl_data;
                if (tbl_data[REG_MSB:REG_LSB] == DELAY_REG) begin
                    if (tbl_data[VAL_MSB:VAL_LSB] == '0) begin
                        state_d = S_NEXT;
                    end else begin
                        dcnt_d  = DCNT_W'(tbl_data[VAL_MSB:VAL_LSB]) * DCNT_W'(DELAY_UNIT);
                        state_d = S_DELAY;
                    end
                end else begin
                    state_d = S_SEND_ADDR;
                end
            end
            S_SEND_ADDR, S_SEND_REG, S_SEND_VAL: begin
                // NACK wins over a simultaneous ACK
                if (resp_nack) begin
                    retry_d = retry_inc;
                    if (retry_inc <= RTY_W'(MAX_RETRY)) begin
                        ok_d    = 1'b0;
                        gcnt_d  = GCNT_W'(GAP_CYCLES);
                        state_d = S_GAP;
                    end else begin
                        state_d = S_FAIL;
                    end
                end else if (resp) begin
                    case (state)
                        S_SEND_ADDR: state_d = S_SEND_REG;
                        S_SEND_REG:  state_d = S_SEND_VAL;
                        default: begin
                            ok_d    = 1'b1;
                            gcnt_d  = GCNT_W'(GAP_CYCLES);
                            state_d = S_GAP;
                        end
                    endcase
                end
            end
            S_DELAY: begin
                if (dcnt <= DCNT_W'(1)) state_d = S_NEXT;
                else                    dcnt_d  = dcnt - DCNT_W'(1);
            end
            S_GAP: begin
                if (gcnt <= GCNT_W'(1)) state_d = ok ? S_NEXT : S_FETCH;
                else                    gcnt_d  = gcnt - GCNT_W'(1);
            end
            S_NEXT: begin
                retry_d = '0;
                if (index == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    index_d = index + TBL_AW'(1);
                    state_d = S_FETCH;
                end
            end
            S_DONE, S_FAIL: state_d = S_IDLE;
            default:        state_d = S_IDLE;
        endcase
    end

    // Output values for the next cycle; m_req drops for one cycle after each response
    always_comb begin
        m_req_d     = 1'b0;
        m_start_d   = 1'b0;
        m_stop_d    = 1'b0;
        m_byte_d    = '0;
        case (state_d)
            S_SEND_ADDR: begin
                m_req_d   = ~resp;
                m_start_d = 1'b1;
                m_byte_d  = {DEV_ADDR, I2C_WR};
            end
            S_SEND_REG: begin
                m_req_d  = ~resp;
                m_byte_d = ent_d[REG_MSB:REG_LSB];
            end
            S_SEND_VAL: begin
                m_req_d  = ~resp;
                m_stop_d = 1'b1;
                m_byte_d = ent_d[VAL_MSB:VAL_LSB];
            end
            default: ;
        endcase
        busy_d      = !(state_d inside {S_IDLE, S_DONE, S_FAIL});
        done_d      = (state_d == S_DONE);
        error_d     = error;
        err_index_d = err_index;
        if (state == S_IDLE && start) begin
            error_d     = 1'b0;
            err_index_d = '0;
        end
        if (state_d == S_FAIL) begin
            error_d     = 1'b1;
            err_index_d = index;
        end
    end

endmodule
